// File: rtl/mem_arb_pkg.sv
// Shared constants for mem_arbiter: FSM state encoding, granted-port ids and default limits.
package mem_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic PORT_INST = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    localparam int unsigned STARVE_MAX_DEFAULT = 4;
    localparam int unsigned TIMEOUT_DEFAULT    = 255;

    function automatic logic [3:0] starve_inc(input logic [3:0] cnt, input logic [3:0] max_cnt);
        return (cnt >= max_cnt) ? max_cnt : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// BUSY-state watchdog for mem_arbiter: cleared by load_i, counts while en_i, flags at TIMEOUT.
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [7:0] Limit = 8'(TIMEOUT);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == Limit);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port memory bus with data priority and a fetch starvation guard.
// Optional BUSY watchdog with bus_err reporting is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inst_req_F,
    input  logic [AW-1:0] pc_F,
    output logic [DW-1:0] inst_F,
    output logic          inst_mem_ack_F,
    input  logic          data_req_M,
    input  logic          mem_write_M,
    input  logic [AW-1:0] alu_out_M,
    input  logic [DW-1:0] write_data_M,
    input  logic [3:0]    data_be_M,
    output logic [DW-1:0] read_data_M,
    output logic          data_mem_ack_M,
    output logic          bus_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [1:0]    state_q, state_d;
    logic          port_q, port_d;
    logic [3:0]    starve_cnt_q, starve_cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [DW-1:0] inst_q, inst_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          inst_ack_q, inst_ack_d;
    logic          data_ack_q, data_ack_d;
    logic          grant_data;
    logic          tmo_expire;

    // Data wins a tie unless fetch has already been passed over StarveMax times.
    assign grant_data = data_req_M && !(inst_req_F && (starve_cnt_q == StarveMax));

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        inst_d       = inst_q;
        rdata_d      = rdata_q;
        inst_ack_d   = 1'b0;
        data_ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!inst_req_F) begin
                    starve_cnt_d = '0;
                end
                if (inst_req_F || data_req_M) begin
                    state_d   = BUSY;
                    mem_req_d = 1'b1;
                    if (grant_data) begin
                        port_d      = PORT_DATA;
                        mem_we_d    = mem_write_M;
                        mem_addr_d  = alu_out_M;
                        mem_wdata_d = write_data_M;
                        mem_be_d    = data_be_M;
                        if (inst_req_F) begin
                            starve_cnt_d = starve_inc(starve_cnt_q, StarveMax);
                        end
                    end else begin
                        port_d       = PORT_INST;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = pc_F;
                        mem_wdata_d  = '0;
                        mem_be_d     = 4'hF;
                        starve_cnt_d = '0;
                    end
                end
            end
            BUSY: begin
                if (mem_ack || tmo_expire) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (port_q == PORT_DATA) begin
                        data_ack_d = 1'b1;
                    end else begin
                        inst_ack_d = 1'b1;
                    end
                    // A timeout leaves the read registers untouched.
                    if (mem_ack && !mem_we_q) begin
                        if (port_q == PORT_DATA) begin
                            rdata_d = mem_rdata;
                        end else begin
                            inst_d = mem_rdata;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            port_q       <= PORT_INST;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            inst_q       <= '0;
            rdata_q      <= '0;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            inst_q       <= inst_d;
            rdata_q      <= rdata_d;
            inst_ack_q   <= inst_ack_d;
            data_ack_q   <= data_ack_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic bus_err_q;

    mem_arb_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (state_q == IDLE),
        .en_i    (state_q == BUSY),
        .expire_o(tmo_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= (state_q == BUSY) && !mem_ack && tmo_expire;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign tmo_expire = 1'b0;
    assign bus_err    = 1'b0;
`endif

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_be         = mem_be_q;
    assign inst_F         = inst_q;
    assign read_data_M    = rdata_q;
    assign inst_mem_ack_F = inst_ack_q;
    assign data_mem_ack_M = data_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned SMAX = 4;
    localparam int unsigned TMO  = 8;

    logic        clk;
    logic        reset;
    logic        inst_req_F;
    logic [31:0] pc_F;
    logic [31:0] inst_F;
    logic        inst_mem_ack_F;
    logic        data_req_M;
    logic        mem_write_M;
    logic [31:0] alu_out_M;
    logic [31:0] write_data_M;
    logic [3:0]  data_be_M;
    logic [31:0] read_data_M;
    logic        data_mem_ack_M;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_inst;
    logic [31:0] exp_rd;

    mem_arbiter #(
        .AW(32),
        .DW(32),
        .STARVE_MAX(SMAX),
        .TIMEOUT(TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .inst_req_F    (inst_req_F),
        .pc_F          (pc_F),
        .inst_F        (inst_F),
        .inst_mem_ack_F(inst_mem_ack_F),
        .data_req_M    (data_req_M),
        .mem_write_M   (mem_write_M),
        .alu_out_M     (alu_out_M),
        .write_data_M  (write_data_M),
        .data_be_M     (data_be_M),
        .read_data_M   (read_data_M),
        .data_mem_ack_M(data_mem_ack_M),
        .bus_err       (bus_err),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory device: sparse array with a deterministic fill pattern for untouched words.
    logic [31:0] mem_arr [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] be);
        logic [31:0] v;
        v = mem_rd(a);
        for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
        mem_arr[a] = v;
    endfunction

    int          lat       = 0;
    bit          resp_en   = 1'b0;
    logic        man_ack   = 1'b0;
    logic [31:0] man_data  = 32'h0;
    logic        ack_r     = 1'b0;
    logic [31:0] resp_data = 32'h0;
    int          rcnt      = 0;

    assign mem_ack   = ack_r | man_ack;
    assign mem_rdata = ack_r ? resp_data : man_data;

    // Responder: acks after `lat` extra BUSY cycles, one-cycle pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (ack_r) begin
                ack_r = 1'b0;
                rcnt  = 0;
            end else if (resp_en && mem_req) begin
                if (rcnt >= lat) begin
                    ack_r     = 1'b1;
                    resp_data = mem_rd(mem_addr);
                    if (mem_we) mem_wr(mem_addr, mem_wdata, mem_be);
                end else begin
                    rcnt++;
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        return $urandom() & 32'hFFFF_FFFC;
    endfunction

    task automatic test_reset;
        #1;
        checks++;
        if ({mem_req, inst_mem_ack_F, data_mem_ack_M, bus_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000",
                     {mem_req, inst_mem_ack_F, data_mem_ack_M, bus_err});
        end
        checks++;
        if ({inst_F, read_data_M} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", {inst_F, read_data_M});
        end
        checks++;
        if ({mem_we, mem_addr, mem_wdata, mem_be} !== 69'h0) begin
            errors++;
            $display("FAIL reset_bus got %h want 0", {mem_we, mem_addr, mem_wdata, mem_be});
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({mem_req, inst_mem_ack_F, data_mem_ack_M, dut.starve_cnt_q} !== 7'h0) begin
            errors++;
            $display("FAIL reset_idle got %h want 0",
                     {mem_req, inst_mem_ack_F, data_mem_ack_M, dut.starve_cnt_q});
        end
    endtask

    task automatic test_fetch_alone;
        mem_arr[32'h0000_0040] = 32'h2402_0005;
        lat        = 0;
        resp_en    = 1'b1;
        pc_F       = 32'h0000_0040;
        inst_req_F = 1'b1;
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, inst_mem_ack_F} !== {1'b1, 1'b0, 32'h40, 1'b0}) begin
            errors++;
            $display("FAIL fetch_c1 got req=%b we=%b addr=%h ack=%b want 1 0 00000040 0",
                     mem_req, mem_we, mem_addr, inst_mem_ack_F);
        end
        tick();
        checks++;
        if ({mem_req, inst_mem_ack_F, data_mem_ack_M} !== 3'b010) begin
            errors++;
            $display("FAIL fetch_c2 got req/iack/dack=%b want 010",
                     {mem_req, inst_mem_ack_F, data_mem_ack_M});
        end
        checks++;
        if (inst_F !== 32'h2402_0005) begin
            errors++;
            $display("FAIL fetch_word got %h want 24020005", inst_F);
        end
        inst_req_F = 1'b0;
        exp_inst   = 32'h2402_0005;
        tick();
        checks++;
        if ({mem_req, inst_mem_ack_F} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_c3 got req/iack=%b want 00", {mem_req, inst_mem_ack_F});
        end
    endtask

    task automatic test_simultaneous;
        logic [31:0] da, ia, dexp, iexp;
        int dcyc, icyc, l;
        da   = rand_addr();
        ia   = rand_addr();
        dexp = mem_rd(da);
        iexp = mem_rd(ia);
        l    = $urandom_range(0, 2);
        lat  = l;
        pc_F        = ia;
        inst_req_F  = 1'b1;
        alu_out_M   = da;
        mem_write_M = 1'b0;
        data_be_M   = 4'hF;
        data_req_M  = 1'b1;
        dcyc = -1;
        icyc = -1;
        for (int c = 1; c <= 30 && icyc < 0; c++) begin
            tick();
            if (data_mem_ack_M) begin
                if (dcyc < 0) dcyc = c;
                data_req_M = 1'b0;
            end
            if (inst_mem_ack_F) begin
                icyc       = c;
                inst_req_F = 1'b0;
            end
        end
        checks++;
        if (dcyc != 2 + l) begin
            errors++;
            $display("FAIL simul_data_cycle got %0d want %0d", dcyc, 2 + l);
        end
        checks++;
        if (icyc != 5 + 2 * l) begin
            errors++;
            $display("FAIL simul_inst_cycle got %0d want %0d", icyc, 5 + 2 * l);
        end
        checks++;
        if ({read_data_M, inst_F} !== {dexp, iexp}) begin
            errors++;
            $display("FAIL simul_data got %h/%h want %h/%h", read_data_M, inst_F, dexp, iexp);
        end
        exp_rd   = dexp;
        exp_inst = iexp;
        inst_req_F = 1'b0;
        data_req_M = 1'b0;
        tick();
    endtask

    task automatic test_write;
        logic [31:0] old;
        old          = mem_rd(32'h1000_0010);
        lat          = 3;
        alu_out_M    = 32'h1000_0010;
        write_data_M = 32'hCAFE_F00D;
        data_be_M    = 4'b0011;
        mem_write_M  = 1'b1;
        data_req_M   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, data_mem_ack_M} !==
                {1'b1, 1'b1, 32'h1000_0010, 32'hCAFE_F00D, 4'b0011, 1'b0}) begin
                errors++;
                $display("FAIL write_busy c%0d got req=%b we=%b a=%h d=%h be=%b ack=%b", c,
                         mem_req, mem_we, mem_addr, mem_wdata, mem_be, data_mem_ack_M);
            end
        end
        tick();
        checks++;
        if ({data_mem_ack_M, mem_req, read_data_M} !== {1'b1, 1'b0, exp_rd}) begin
            errors++;
            $display("FAIL write_ack got ack=%b req=%b rd=%h want 1 0 %h",
                     data_mem_ack_M, mem_req, read_data_M, exp_rd);
        end
        data_req_M  = 1'b0;
        mem_write_M = 1'b0;
        tick();
        lat        = 0;
        data_be_M  = 4'hF;
        data_req_M = 1'b1;
        tick();
        tick();
        checks++;
        if ({data_mem_ack_M, read_data_M} !== {1'b1, old[31:16], 16'hF00D}) begin
            errors++;
            $display("FAIL write_readback got ack=%b rd=%h want 1 %h",
                     data_mem_ack_M, read_data_M, {old[31:16], 16'hF00D});
        end
        exp_rd     = {old[31:16], 16'hF00D};
        data_req_M = 1'b0;
        tick();
    endtask

    task automatic test_starvation;
        int  nd;
        bit  got;
        logic [31:0] want;
        nd  = 0;
        got = 1'b0;
        lat = $urandom_range(0, 1);
        pc_F        = rand_addr();
        inst_req_F  = 1'b1;
        mem_write_M = 1'b0;
        alu_out_M   = rand_addr();
        data_req_M  = 1'b1;
        for (int c = 0; c < 60 && !got; c++) begin
            tick();
            if (data_mem_ack_M) begin
                nd++;
                want = mem_rd(alu_out_M);
                checks++;
                if (read_data_M !== want) begin
                    errors++;
                    $display("FAIL starve_rd got %h want %h", read_data_M, want);
                end
                exp_rd    = want;
                alu_out_M = rand_addr();
            end
            if (inst_mem_ack_F) got = 1'b1;
        end
        checks++;
        if (!got || nd != int'(SMAX)) begin
            errors++;
            $display("FAIL starve_grants got data=%0d fetch=%0d want %0d 1", nd, got, SMAX);
        end
        checks++;
        if ({dut.starve_cnt_q, inst_F} !== {4'd0, mem_rd(pc_F)}) begin
            errors++;
            $display("FAIL starve_reset got cnt=%0d inst=%h want 0 %h",
                     dut.starve_cnt_q, inst_F, mem_rd(pc_F));
        end
        exp_inst   = mem_rd(pc_F);
        inst_req_F = 1'b0;
        data_req_M = 1'b0;
        tick();
        tick();
    endtask

    // Transaction-level model: at each IDLE decision pick a port by priority/starvation,
    // then the transaction occupies 3+L cycles with its ack in cycle 2+L.
    task automatic test_random;
        int  next_dec, done_cyc, grant_cyc, starve_m, l, errs0;
        bit  busy_m, port_m, we_m, gd, iack_e, dack_e;
        logic [31:0] addr_m, wd_m, val_m;
        logic [3:0]  be_m;
        next_dec = 0;
        done_cyc = -1;
        grant_cyc = -1;
        starve_m = 0;
        busy_m   = 1'b0;
        port_m   = 1'b0;
        we_m     = 1'b0;
        addr_m   = '0;
        wd_m     = '0;
        be_m     = '0;
        val_m    = '0;
        errs0    = errors;
        resp_en  = 1'b1;
        for (int c = 0; c < 700; c++) begin
            iack_e = busy_m && (c == done_cyc) && !port_m;
            dack_e = busy_m && (c == done_cyc) && port_m;
            if (busy_m && c == done_cyc && !we_m) begin
                if (port_m) exp_rd = val_m;
                else exp_inst = val_m;
            end
            checks++;
            if ({inst_mem_ack_F, data_mem_ack_M, mem_req, bus_err, inst_F, read_data_M} !==
                {iack_e, dack_e, busy_m && c < done_cyc, 1'b0, exp_inst, exp_rd}) begin
                errors++;
                $display("FAIL rand_c%0d got ia=%b da=%b rq=%b be=%b i=%h d=%h want %b %b %b 0 %h %h",
                         c, inst_mem_ack_F, data_mem_ack_M, mem_req, bus_err, inst_F, read_data_M,
                         iack_e, dack_e, busy_m && c < done_cyc, exp_inst, exp_rd);
            end
            if (busy_m && c == grant_cyc + 1) begin
                checks++;
                if ({mem_we, mem_addr} !== {we_m, addr_m} ||
                    (we_m && {mem_wdata, mem_be} !== {wd_m, be_m})) begin
                    errors++;
                    $display("FAIL rand_fields c%0d got we=%b a=%h d=%h be=%b want %b %h %h %b",
                             c, mem_we, mem_addr, mem_wdata, mem_be, we_m, addr_m, wd_m, be_m);
                end
            end
            if (busy_m && c == done_cyc) begin
                busy_m = 1'b0;
                if (port_m) data_req_M = 1'b0;
                else inst_req_F = 1'b0;
            end
            if (c < 660) begin
                if (!inst_req_F && $urandom_range(0, 2) == 0) begin
                    inst_req_F = 1'b1;
                    pc_F       = rand_addr();
                end
                if (!data_req_M && $urandom_range(0, 2) != 0) begin
                    data_req_M   = 1'b1;
                    mem_write_M  = $urandom_range(0, 2) == 0;
                    alu_out_M    = {28'h000_0100 | 28'($urandom_range(0, 15)), 4'h0};
                    write_data_M = $urandom();
                    data_be_M    = 4'($urandom_range(1, 15));
                end
            end
            if (!busy_m && c >= next_dec) begin
                if (!inst_req_F) starve_m = 0;
                if (inst_req_F || data_req_M) begin
                    gd = data_req_M && !(inst_req_F && starve_m == int'(SMAX));
                    if (gd && inst_req_F) starve_m = (starve_m + 1 > int'(SMAX)) ? SMAX : starve_m + 1;
                    if (!gd) starve_m = 0;
                    l         = $urandom_range(0, 3);
                    lat       = l;
                    busy_m    = 1'b1;
                    port_m    = gd;
                    we_m      = gd ? mem_write_M : 1'b0;
                    addr_m    = gd ? alu_out_M : pc_F;
                    wd_m      = write_data_M;
                    be_m      = data_be_M;
                    val_m     = mem_rd(addr_m);
                    grant_cyc = c;
                    done_cyc  = c + 2 + l;
                    next_dec  = done_cyc + 1;
                end else begin
                    next_dec = c + 1;
                end
            end
            tick();
        end
        inst_req_F = 1'b0;
        data_req_M = 1'b0;
        mem_write_M = 1'b0;
        tick();
        tick();
        if (errors != errs0) $display("random traffic saw %0d bad cycles", errors - errs0);
    endtask

    task automatic test_reset_mid_busy;
        resp_en     = 1'b0;
        mem_write_M = 1'b0;
        alu_out_M   = rand_addr();
        data_be_M   = 4'hF;
        data_req_M  = 1'b1;
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre got req=%b want 1", mem_req);
        end
        reset      = 1'b0;
        data_req_M = 1'b0;
        #1;
        checks++;
        if ({mem_req, inst_mem_ack_F, data_mem_ack_M, bus_err, inst_F, read_data_M,
             mem_we, mem_addr, mem_wdata, mem_be} !== 137'h0) begin
            errors++;
            $display("FAIL rst_mid_now got req=%b ia=%b da=%b be=%b i=%h d=%h a=%h want all 0",
                     mem_req, inst_mem_ack_F, data_mem_ack_M, bus_err, inst_F, read_data_M,
                     mem_addr);
        end
        exp_inst = '0;
        exp_rd   = '0;
        tick();
        reset = 1'b1;
        tick();
        man_data = 32'hDEAD_BEEF;
        man_ack  = 1'b1;
        tick();
        man_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({mem_req, inst_mem_ack_F, data_mem_ack_M, read_data_M, inst_F} !== 67'h0) begin
                errors++;
                $display("FAIL rst_mid_late c%0d got req=%b ia=%b da=%b d=%h want 0", c,
                         mem_req, inst_mem_ack_F, data_mem_ack_M, read_data_M);
            end
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout;
        logic [31:0] a;
        resp_en     = 1'b1;
        lat         = 1;
        mem_write_M = 1'b0;
        data_be_M   = 4'hF;
        alu_out_M   = rand_addr();
        exp_rd      = mem_rd(alu_out_M);
        data_req_M  = 1'b1;
        tick();
        tick();
        tick();
        data_req_M = 1'b0;
        tick();
        resp_en    = 1'b0;
        alu_out_M  = rand_addr();
        data_req_M = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            checks++;
            if ({mem_req, data_mem_ack_M, bus_err} !== 3'b100) begin
                errors++;
                $display("FAIL tmo_wait c%0d got req/ack/err=%b want 100", c,
                         {mem_req, data_mem_ack_M, bus_err});
            end
        end
        tick();
        checks++;
        if ({mem_req, data_mem_ack_M, bus_err, read_data_M} !== {3'b011, exp_rd}) begin
            errors++;
            $display("FAIL tmo_fire got req/ack/err=%b rd=%h want 011 %h",
                     {mem_req, data_mem_ack_M, bus_err}, read_data_M, exp_rd);
        end
        data_req_M = 1'b0;
        tick();
        resp_en    = 1'b1;
        lat        = 0;
        a          = rand_addr();
        alu_out_M  = a;
        data_req_M = 1'b1;
        tick();
        tick();
        checks++;
        if ({data_mem_ack_M, bus_err, read_data_M} !== {2'b10, mem_rd(a)}) begin
            errors++;
            $display("FAIL tmo_after got ack/err=%b rd=%h want 10 %h",
                     {data_mem_ack_M, bus_err}, read_data_M, mem_rd(a));
        end
        data_req_M = 1'b0;
        tick();
    endtask
`endif

    initial begin
        reset        = 1'b0;
        inst_req_F   = 1'b0;
        pc_F         = '0;
        data_req_M   = 1'b0;
        mem_write_M  = 1'b0;
        alu_out_M    = '0;
        write_data_M = '0;
        data_be_M    = '0;
        exp_inst     = '0;
        exp_rd       = '0;
        test_reset();
        test_fetch_alone();
        test_simultaneous();
        test_write();
        test_starvation();
        test_random();
        test_reset_mid_busy();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
